// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x-oversampled UART receiver with a valid/ready output.
// Ports:
//   i_clk, i_rst_n  - system clock, asynchronous active-low reset
//   i_rx_serial     - asynchronous serial line, idle high
//   i_rx_ready      - consumer accepts o_rx_data this cycle
//   o_rx_data       - last accepted received word
//   o_rx_valid      - o_rx_data holds an unconsumed word
//   o_frame_err     - one-cycle pulse: stop bit sampled low
//   o_overrun       - one-cycle pulse: word completed while the previous one was still pending
//   o_busy          - receiver is not idle
module uart_rx_oversample #(
  parameter int unsigned SIZE_DATA      = 8,
  parameter int unsigned BAUDRATE_VALUE = 325,
  parameter int unsigned OVER_SAMPLE    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_serial,
  input  logic                 i_rx_ready,
  output logic [SIZE_DATA-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned DIV_W  = (BAUDRATE_VALUE > 0) ? $clog2(BAUDRATE_VALUE + 1) : 1;
  localparam int unsigned BIT_W  = $clog2(SIZE_DATA) + 1;
  localparam int unsigned TICK_W = 4;

  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(BAUDRATE_VALUE);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVER_SAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVER_SAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(SIZE_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchroniser plus edge-detect flop; reset high so a released reset never looks like a start edge.
  logic rx_meta, rx_s, rx_d;
  logic rx_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign rx_fall = rx_d & ~rx_s;

  // Free-running 16x baud tick generator.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Receive FSM state.
  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SIZE_DATA-1:0] shift_q, shift_d;
  logic                 done_c;
  logic                 frame_err_c;

  // Next-state logic; done_c marks a good stop bit, frame_err_c a bad one.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    done_c      = 1'b0;
    frame_err_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt_q == MID_TICK) begin
            // Line must still be low half a bit in, otherwise it was a glitch.
            if (!rx_s) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            shift_d    = {rx_s, shift_q[SIZE_DATA-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tick_cnt_q == LAST_TICK) begin
            state_d     = IDLE;
            tick_cnt_d  = '0;
            done_c      = rx_s;
            frame_err_c = ~rx_s;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      o_frame_err <= frame_err_c;
      o_overrun   <= done_c & o_rx_valid & ~i_rx_ready;
      o_busy      <= (state_d != IDLE);

      // A new word is accepted only if the output slot is free or being drained this cycle.
      if (done_c) begin
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_data  <= shift_q;
          o_rx_valid <= 1'b1;
        end
      end else if (i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
UART receiver, the receive-side counterpart of the team's 16x-oversampled UART transmitter.
- Synchronises the asynchronous serial line.
- Generates its own 16x baud tick.
- Validates the start bit, samples SIZE_DATA data bits LSB-first at mid-bit and checks one stop bit.
- Presents each received byte on a valid/ready handshake toward the FPGA-side consumer (FIFO or test logic).
- Flags framing and overrun errors.

Parameters:
- SIZE_DATA, 8: number of data bits per frame.
- BAUDRATE_VALUE, 325: tick divider, FREQ / (BAUDRATE * 16) - 1. One tick every BAUDRATE_VALUE+1 clocks.
- OVER_SAMPLE, 16: ticks per bit; fixed at 16, must be even.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_rx_serial  in  1  asynchronous serial line, idle high.
- i_rx_ready  in  1  consumer accepts o_rx_data this cycle.
- o_rx_data  out  SIZE_DATA  last accepted received word.
- o_rx_valid  out  1  o_rx_data holds an unconsumed word.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: frame completed while o_rx_valid=1 and i_rx_ready=0.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: o_rx_data=0, o_rx_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, state=IDLE, tick/bit counters=0, synchroniser flops=1 (prevents a false start after reset).
- Reset mid-frame: immediate return to IDLE; the partial word is discarded.
- Synchroniser: 2-flop synchroniser on i_rx_serial gives rx_s. A falling-edge detector on rx_s uses a third flop.
- Baud tick:
  - Free-running counter 0..BAUDRATE_VALUE.
  - tick=1 for one clock when the counter equals BAUDRATE_VALUE; the counter wraps to 0 on that cycle.
  - BAUDRATE_VALUE=0 gives tick every clock.
- FSM states: IDLE, START, DATA, STOP. Transitions:
  - IDLE: a falling edge on rx_s goes to START and clears tick_cnt.
  - START: tick_cnt increments per tick. On the tick where tick_cnt reaches OVER_SAMPLE/2-1 (=7), sample rx_s.
    - If rx_s=0: clear tick_cnt and bit_cnt, go to DATA.
    - If rx_s=1: glitch; return to IDLE with no output activity.
  - DATA: on the tick where tick_cnt reaches 15 (mid-bit):
    - Shift rx_s into the shift-register MSB (shift right, LSB-first).
    - Clear tick_cnt.
    - If bit_cnt=SIZE_DATA-1, go to STOP; else increment bit_cnt.
  - STOP: on the tick where tick_cnt reaches 15, sample rx_s, then go to IDLE on the same clock.
    - rx_s=1: frame good, completion event.
    - rx_s=0: o_frame_err pulses for 1 clock; the word is discarded; o_rx_valid and o_rx_data are unchanged.
  - A new start bit can be detected in IDLE the cycle after leaving STOP. Back-to-back frames with no idle gap must be received.
- Handshake on completion event:
  - o_rx_valid=0: load o_rx_data and set o_rx_valid=1 on the next edge.
  - o_rx_valid=1 and i_rx_ready=1 in the same cycle: load the new word, o_rx_valid stays 1, no overrun.
  - o_rx_valid=1 and i_rx_ready=0: o_overrun pulses 1 clock; the new word is dropped; the old word is retained.
- Handshake without a completion event: i_rx_ready=1 while o_rx_valid=1 clears o_rx_valid next edge. i_rx_ready while o_rx_valid=0 is ignored.
- Latency: o_rx_valid rises 1 clock after the tick that samples the stop bit, about 9.5 bit times after the start edge.
- Width rules:
  - tick_cnt is 4 bits.
  - bit_cnt is clog2(SIZE_DATA)+1 bits wide.
  - The divider counter is wide enough for BAUDRATE_VALUE; at default 325 that is 9 bits.
- o_frame_err and o_overrun are never asserted in the same cycle as each other.

Test Plan:
1. BAUDRATE_VALUE=3 (bit = 64 clocks), i_rx_ready=1 held. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> o_rx_valid high for exactly 1 cycle, o_rx_data=0xA5, no error pulses.
2. i_rx_ready=0. Send 0x3C, then 0xC3 back-to-back with no idle gap -> first: o_rx_valid=1, data 0x3C. Second: o_overrun pulses once, o_rx_data stays 0x3C. Raise i_rx_ready -> o_rx_valid clears next clock.
3. Stop bit driven low, data 0x55 -> o_frame_err pulses 1 cycle, o_rx_valid stays 0, FSM returns to IDLE. A following good 0x0F frame is received correctly.
4. 2-tick low glitch (8 clocks) on the idle line -> FSM enters START and returns to IDLE at the mid-start sample; no valid or error pulses.
5. Assert i_rst_n=0 during data bit 4 of a frame -> all outputs 0 immediately. After release with the line idle, a new 0x81 frame is received correctly.
6. o_rx_valid=1 holding 0x11; new 0x22 completes in the same cycle i_rx_ready=1 -> o_rx_data=0x22, o_rx_valid stays 1, no o_overrun.
